// File: rtl/bcd_pkg.sv
// ============================================================================
// Module   : bcd_pkg
// Brief    : Shared types and helpers for the BCD window normalizer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef logic [3:0] bcd_digit_t;

  function automatic logic bcd_is_zero_digit(input bcd_digit_t d);
    return (d == 4'h0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_incrementer.sv
// ============================================================================
// Module   : bcd_incrementer
// Brief    : Combinational decimal +1 across OUT_DIGITS BCD digits, ripple carry.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_incrementer
  import bcd_pkg::*;
#(
  parameter int OUT_DIGITS = 3
) (
  input  logic [4*OUT_DIGITS-1:0] bcd_i,
  output logic [4*OUT_DIGITS-1:0] bcd_o,
  output logic                    carry_o
);

  bcd_digit_t digit;
  logic       carry;

  always_comb begin
    bcd_o = '0;
    carry = 1'b1;
    digit = '0;
    for (int i = 0; i < OUT_DIGITS; i++) begin
      digit = bcd_i[4*i +: 4];
      if (carry) begin
        if (digit == 4'd9) begin
          bcd_o[4*i +: 4] = 4'd0;
        end else begin
          bcd_o[4*i +: 4] = digit + 4'd1;
          carry           = 1'b0;
        end
      end else begin
        bcd_o[4*i +: 4] = digit;
      end
    end
    carry_o = carry;
  end

endmodule

`default_nettype wire

// File: rtl/bcd_window_normalizer.sv
// ============================================================================
// Module   : bcd_window_normalizer
// Brief    : Strips leading zero digits (capped) and presents an OUT_DIGITS
//            mantissa plus decimal exponent. Define ROUNDING_EN for
//            round-half-up on the first discarded digit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_window_normalizer
  import bcd_pkg::*;
#(
  parameter int DIGITS     = 4,
  parameter int OUT_DIGITS = 3
) (
  input  logic                                    clk_i,
  input  logic                                    reset_ni,
  input  logic                                    start_i,
  input  logic [4*DIGITS-1:0]                     bcd_i,
  output logic                                    ready_o,
  output logic                                    done_o,
  output logic [4*OUT_DIGITS-1:0]                 bcd_o,
  output logic [$clog2(DIGITS-OUT_DIGITS+2)-1:0]  exp_o,
  output logic                                    zero_o
);

  localparam int               CAP   = DIGITS - OUT_DIGITS;
  localparam int               EXP_W = $clog2(DIGITS - OUT_DIGITS + 2);
  localparam int               WIN_W = 4 * OUT_DIGITS;
  localparam logic [EXP_W-1:0] CAP_E = EXP_W'(CAP);

  state_t             state;
  logic [4*DIGITS-1:0] work;
  logic [EXP_W-1:0]   s;
  logic               zero_flag;
  logic               operand_zero;
  logic               can_shift;
  logic [WIN_W-1:0]   window;
  logic [WIN_W-1:0]   final_win;
  logic [EXP_W-1:0]   final_exp;

  always_comb begin
    operand_zero = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (!bcd_is_zero_digit(bcd_i[4*i +: 4])) operand_zero = 1'b0;
    end
  end

  assign window    = work[4*DIGITS-1 -: WIN_W];
  assign can_shift = bcd_is_zero_digit(work[4*DIGITS-1 -: 4]) && (s < CAP_E);

`ifdef ROUNDING_EN
  localparam logic [WIN_W-1:0] CARRY_WIN = WIN_W'(1) << (4 * (OUT_DIGITS - 1));

  logic [WIN_W-1:0] inc_sum;
  logic             inc_carry;
  logic             round_up;

  bcd_incrementer #(
    .OUT_DIGITS (OUT_DIGITS)
  ) u_incrementer (
    .bcd_i   (window),
    .bcd_o   (inc_sum),
    .carry_o (inc_carry)
  );

  // Only a window that was not fully shifted has a discarded digit beneath it.
  if (CAP > 0) begin : g_round_digit
    assign round_up = (s < CAP_E) && (work[4*(CAP-1) +: 4] >= 4'd5);
  end else begin : g_no_round_digit
    assign round_up = 1'b0;
  end

  assign final_win = !round_up ? window : (inc_carry ? CARRY_WIN : inc_sum);
  assign final_exp = CAP_E - s + EXP_W'(round_up && inc_carry);
`else
  assign final_win = window;
  assign final_exp = CAP_E - s;
`endif

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state     <= IDLE;
      work      <= '0;
      s         <= '0;
      zero_flag <= 1'b0;
      ready_o   <= 1'b1;
      done_o    <= 1'b0;
      bcd_o     <= '0;
      exp_o     <= '0;
      zero_o    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            work      <= bcd_i;
            s         <= '0;
            zero_flag <= operand_zero;
            ready_o   <= 1'b0;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          if (can_shift) begin
            work <= work << 4;
            s    <= s + EXP_W'(1);
          end else begin
`ifdef ROUNDING_EN
            state  <= ROUND;
`else
            state  <= DONE;
            done_o <= 1'b1;
            bcd_o  <= final_win;
            exp_o  <= final_exp;
            zero_o <= zero_flag;
`endif
          end
        end
`ifdef ROUNDING_EN
        ROUND: begin
          state  <= DONE;
          done_o <= 1'b1;
          bcd_o  <= final_win;
          exp_o  <= final_exp;
          zero_o <= zero_flag;
        end
`endif
        DONE: begin
          done_o  <= 1'b0;
          ready_o <= 1'b1;
          state   <= IDLE;
        end
        default: begin
          state   <= IDLE;
          ready_o <= 1'b1;
          done_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/bcd_window_normalizer.md
# bcd_window_normalizer

- Parametrised successor to the fixed-width BCD normalizer in the auto-scaled frequency counter path.
- Takes a DIGITS-wide BCD count and left-shifts out leading zero digits, with the shift capped so the exponent never goes negative.
- Presents the top OUT_DIGITS digits as a mantissa plus a decimal exponent, so the display shows value = bcd_o × 10^exp_o.
- Optional round-half-up on the first discarded digit.

## Interface
- DIGITS, 4: input width in BCD digits (≥1).
- OUT_DIGITS, 3: output window width in digits (1 ≤ OUT_DIGITS ≤ DIGITS).
- clk_i  in  1  single clock, rising edge.
- reset_ni  in  1  reset, asynchronous, active-low.
- start_i  in  1  request; sampled only while ready_o=1.
- bcd_i  in  4*DIGITS  BCD operand, captured with start.
- ready_o  out  1  high in IDLE only.
- done_o  out  1  one-cycle pulse, result valid.
- bcd_o  out  4*OUT_DIGITS  mantissa window, registered.
- exp_o  out  $clog2(DIGITS-OUT_DIGITS+2)  decimal exponent, registered.
- zero_o  out  1  operand was all-zero digits.

## Operation
- Let CAP = DIGITS-OUT_DIGITS.
- States:
  - IDLE: on start_i, load the working register with bcd_i and clear the shift count s. Go to SHIFT.
  - SHIFT: if MSD==0 and s<CAP, shift left one digit (zero-fill) and s++. Otherwise go to ROUND when ROUNDING_EN is defined, else go to DONE.
  - ROUND: one cycle; see Configuration.
  - DONE: done_o=1, then go to IDLE.
- Window = top OUT_DIGITS digits of the working register. exp_o = CAP - s + c, where c is the rounding carry.
- Result registers (bcd_o, exp_o, zero_o) load on the transition into DONE. They hold until the next load.
- zero_o=1 iff the captured operand had every digit ==0. The mantissa is then 0 and the exponent is 0.
- Non-decimal digits (A–F) are not checked. They are treated as nonzero and pass through.
- start_i while not IDLE: ignored, with no queuing.
- OUT_DIGITS==DIGITS: CAP=0, no shifts, mantissa = input.

## Timing
- Reset (asynchronous, active-low):
  - state IDLE, working register 0, s=0.
  - bcd_o=0, exp_o=0, zero_o=0, done_o=0, ready_o=1.
- Let capture edge = edge E where start_i is sampled in IDLE, and k = shifts performed (0..CAP).
- Without ROUNDING_EN: done_o is high in the cycle after edge E+k+1. Start-to-done latency is k+2 cycles.
- With ROUNDING_EN: one cycle later, k+3 cycles.
- ready_o returns high the cycle after the done_o pulse. A new start is accepted on that edge, so back-to-back throughput is one result every k+3 (or k+4) cycles.
- Outputs are stable during and after the done_o pulse.
- Reset asserted mid-operation: abort immediately. No done_o. Outputs return to reset values.

## Configuration
- ROUNDING_EN defined:
  - ROUND state inspects the discarded digit d at index CAP-1, only if s<CAP.
  - If d≥5, the window gets a BCD +1 with decimal ripple carry.
  - Carry out of the top digit: window = 1 followed by OUT_DIGITS-1 zeros, and c=1.
  - If s==CAP there is no discarded digit and the window is unchanged.
- ROUNDING_EN undefined:
  - ROUND state, incrementer and carry logic are not compiled. The window is truncated and c=0.
  - Latency is one cycle shorter.

## Structure
- Package bcd_pkg:
  - state enum (IDLE, SHIFT, ROUND, DONE).
  - bcd_digit_t (4-bit) typedef.
  - function bcd_is_zero_digit.
- Sub-module bcd_incrementer (parameter OUT_DIGITS):
  - purely combinational decimal +1 with carry_o.
  - instantiated only under ROUNDING_EN.

## Test plan
All cases use DIGITS=4, OUT_DIGITS=3.
- 0x0123 -> bcd_o=0x123, exp_o=0, zero_o=0, done_o 3 cycles after start (4 with rounding).
- 0x1234 -> bcd_o=0x123, exp_o=1, k=0 in both builds, since digit 4 does not round.
- 0x1235 -> with ROUNDING_EN bcd_o=0x124, exp_o=1; without, 0x123, exp_o=1.
- 0x9996 -> with ROUNDING_EN bcd_o=0x100, exp_o=2; without, 0x999, exp_o=1.
- 0x0000 -> one shift (cap), bcd_o=0x000, exp_o=0, zero_o=1.
- Ignored start and mid-operation reset:
  - start 0x0012, pulse start_i again with 0x9999 while busy: the second start is ignored and the result is 0x012/exp 0.
  - then assert reset_ni=0 during SHIFT of the next operation: no done_o, all outputs 0, ready_o=1.
